// File: rtl/fancytimer_pkg.sv
// Shared types and constants for the fancy-timer scheduler.
//  sched_state_e : scheduler FSM states
//  START_PATTERN : 4-bit preamble that the timer recognises as a start frame
//  FRAME_BITS    : total serial frame length (preamble + 4-bit delay)
package fancytimer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_CNT,
        RUN,
        ACK,
        DONE
    } sched_state_e;

    localparam logic [3:0] START_PATTERN = 4'b1101;
    localparam int         FRAME_BITS    = 8;

endpackage

// File: rtl/fancytimer_sched_rr_pick.sv
// Round-robin picker, purely combinational.
// Ports:
//  i_req   [N_REQ]  pending request vector
//  i_ptr   [PTR_W]  index with highest priority this round
//  o_win   [N_REQ]  one-hot winner (zero when nothing pending)
//  o_idx   [PTR_W]  index of the winner
//  o_valid          at least one request pending
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    // Walk the offsets from the farthest to the nearest so the request closest
    // to i_ptr (going upwards with wrap) is the last one written and wins.
    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(i_ptr) + k) % N_REQ;
            if (i_req[idx]) begin
                o_win      = '0;
                o_win[idx] = 1'b1;
                o_idx      = PTR_W'(idx);
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fancytimer_sched.sv
// Shares one fancy timer between N_REQ requesters. A round-robin pick selects a
// pending request, its 8-bit start frame {1101, delay} is shifted out MSB first on
// tmr_data, then the scheduler waits for counting/done, acks the timer and pulses
// cmpl for the owner.
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  req   [N_REQ]         level requests, held until the matching cmpl
//  delay [4*N_REQ]       per-requester 4-bit delay
//  grant [N_REQ]         one-hot current owner, 0 when idle
//  cmpl  [N_REQ]         one-cycle completion pulse for the owner
//  busy                  timer owned
//  err                   sticky start-timeout flag
//  tmr_data, tmr_ack     serial start line and ack towards the timer
//  tmr_counting, tmr_done status from the timer
module fancytimer_sched
    import fancytimer_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int START_TMO = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] delay,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   cmpl,
    output logic               busy,
    output logic               err,
    output logic               tmr_data,
    output logic               tmr_ack,
    input  logic               tmr_counting,
    input  logic               tmr_done
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TMO_W = $clog2(START_TMO + 1);

    sched_state_e     r_state, w_state_next;
    logic [N_REQ-1:0] r_grant, w_grant_next;
    logic [N_REQ-1:0] r_cmpl, w_cmpl_next;
    logic             r_err, w_err_next;
    logic             r_tmr_data, w_tmr_data_next;
    logic             r_tmr_ack, w_tmr_ack_next;
    logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_next;
    logic [PTR_W-1:0] r_owner, w_owner_next;
    logic [3:0]       r_dly, w_dly_next;
    logic [2:0]       r_bit_cnt, w_bit_cnt_next;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_next;

    logic [N_REQ-1:0] w_win;
    logic [PTR_W-1:0] w_win_idx;
    logic             w_win_valid;
    logic [7:0]       w_frame;
    logic [3:0]       w_dly_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dly
            assign w_dly_arr[gi] = delay[4*gi +: 4];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_win   (w_win),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    assign w_frame = {START_PATTERN, r_dly};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_cmpl     <= '0;
            r_err      <= 1'b0;
            r_tmr_data <= 1'b0;
            r_tmr_ack  <= 1'b0;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_dly      <= '0;
            r_bit_cnt  <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_cmpl     <= w_cmpl_next;
            r_err      <= w_err_next;
            r_tmr_data <= w_tmr_data_next;
            r_tmr_ack  <= w_tmr_ack_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_owner    <= w_owner_next;
            r_dly      <= w_dly_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tmo_cnt  <= w_tmo_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_cmpl_next     = '0;
        w_err_next      = r_err;
        w_tmr_data_next = 1'b0;
        w_tmr_ack_next  = 1'b0;
        w_rr_ptr_next   = r_rr_ptr;
        w_owner_next    = r_owner;
        w_dly_next      = r_dly;
        w_bit_cnt_next  = r_bit_cnt;
        w_tmo_cnt_next  = r_tmo_cnt;

        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_grant_next    = w_win;
                    w_owner_next    = w_win_idx;
                    w_dly_next      = w_dly_arr[w_win_idx];
                    w_bit_cnt_next  = '0;
                    // First frame bit goes out together with the grant.
                    w_tmr_data_next = START_PATTERN[3];
                    w_state_next    = SEND;
                end
            end
            SEND: begin
                if (r_bit_cnt == 3'(FRAME_BITS - 1)) begin
                    w_tmo_cnt_next = '0;
                    w_state_next   = WAIT_CNT;
                end else begin
                    w_bit_cnt_next  = r_bit_cnt + 3'd1;
                    // Bit for the next cycle: frame[7 - (bit_cnt + 1)].
                    w_tmr_data_next = w_frame[3'(FRAME_BITS - 2) - r_bit_cnt];
                end
            end
            WAIT_CNT: begin
                if (tmr_counting) begin
                    w_state_next = RUN;
                end else if (r_tmo_cnt == TMO_W'(START_TMO - 1)) begin
                    // Timer never started: drop the job but still complete it.
                    w_err_next   = 1'b1;
                    w_cmpl_next  = r_grant;
                    w_state_next = DONE;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
                end
            end
            RUN: begin
                if (tmr_done) begin
                    w_tmr_ack_next = 1'b1;
                    w_state_next   = ACK;
                end
            end
            ACK: begin
                w_cmpl_next  = r_grant;
                w_state_next = DONE;
            end
            DONE: begin
                w_grant_next  = '0;
                w_rr_ptr_next = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
                w_state_next  = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    assign grant    = r_grant;
    assign cmpl     = r_cmpl;
    assign busy     = (r_state != IDLE);
    assign err      = r_err;
    assign tmr_data = r_tmr_data;
    assign tmr_ack  = r_tmr_ack;

endmodule
